eq_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one external 4-bit `equality` comparator among four requesters. Each requester offers an operand pair with a valid/ready handshake. The arbiter registers the winning pair onto the comparator inputs and samples the comparator's `Equal` output one cycle later. It then returns a tagged result on a single response channel that accepts backpressure. The block sits between requesting logic and the single comparator instance, so the comparator itself stays purely combinational.

---
 rtl/eq_share_arbiter_if.sv | 42 ++++
 rtl/eq_share_arbiter.sv | 173 +++++++++++++++++
 tb/tb_eq_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_share_arbiter_if.sv
// eq_share_arbiter_if: bundle of the requester, comparator and response
// channels of eq_share_arbiter.
//   slave  : the arbiter side (accepts requests, drives comparator and response)
//   master : the surrounding logic (requesters, comparator, result consumer)
interface eq_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;

    logic [W-1:0]      cmp_a;
    logic [W-1:0]      cmp_b;
    logic              cmp_equal;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic              rsp_equal;
    logic [W-1:0]      rsp_a;
    logic [W-1:0]      rsp_b;

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready,
        output cmp_a, cmp_b,
        input  cmp_equal,
        output rsp_valid, rsp_id, rsp_equal, rsp_a, rsp_b,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready,
        input  cmp_a, cmp_b,
        output cmp_equal,
        input  rsp_valid, rsp_id, rsp_equal, rsp_a, rsp_b,
        output rsp_ready
    );
endinterface

// File: rtl/eq_share_arbiter.sv
// eq_share_arbiter: round-robin arbiter/sequencer sharing one external
// combinational 4-bit equality comparator among four requesters.
// One compare in flight at a time: IDLE (grant) -> CMP (comparator settles)
// -> RSP (result held until consumed).
// Optional feature macro: EQ_ARB_STATS_EN adds saturating 8-bit counters
// stat_cmps (completed responses) and stat_matches (those with equal = 1).
module eq_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eq_share_arbiter_if.slave    bus
`ifdef EQ_ARB_STATS_EN
    ,
    output logic [7:0]           stat_cmps,
    output logic [7:0]           stat_matches
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     rr_q, rr_d;
    logic [1:0]     owner_q, owner_d;
    logic [W-1:0]   cmp_a_q, cmp_a_d;
    logic [W-1:0]   cmp_b_q, cmp_b_d;
    logic [1:0]     rsp_id_q, rsp_id_d;
    logic           rsp_equal_q, rsp_equal_d;
    logic [W-1:0]   rsp_a_q, rsp_a_d;
    logic [W-1:0]   rsp_b_q, rsp_b_d;

    logic [NREQ-1:0] grant;
    logic           win_found;
    logic [1:0]     win_idx;
    logic [1:0]     cand;

    // Per-requester operand views of the packed request buses.
    logic [W-1:0]   op_a [NREQ];
    logic [W-1:0]   op_b [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
        assign op_a[gi] = bus.req_a[gi*W +: W];
        assign op_b[gi] = bus.req_b[gi*W +: W];
    end

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_q + 2'(k);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and grant logic; every register holds unless its phase updates it.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        cmp_a_d     = cmp_a_q;
        cmp_b_d     = cmp_b_q;
        rsp_id_d    = rsp_id_q;
        rsp_equal_d = rsp_equal_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        grant       = '0;
        case (state_q)
            IDLE: begin
                // The grant only goes to a valid requester, so a grant is
                // always a handshake. Held off while reset is asserted.
                if (win_found && rst_n) begin
                    grant[win_idx] = 1'b1;
                    cmp_a_d        = op_a[win_idx];
                    cmp_b_d        = op_b[win_idx];
                    owner_d        = win_idx;
                    rr_d           = win_idx + 2'd1;
                    state_d        = CMP;
                end
            end
            CMP: begin
                rsp_equal_d = bus.cmp_equal;
                rsp_id_d    = owner_q;
                rsp_a_d     = cmp_a_q;
                rsp_b_d     = cmp_b_q;
                state_d     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            rsp_id_q    <= '0;
            rsp_equal_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_equal_q <= rsp_equal_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.cmp_a     = cmp_a_q;
    assign bus.cmp_b     = cmp_b_q;
    assign bus.rsp_valid = (state_q == RSP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_equal = rsp_equal_q;
    assign bus.rsp_a     = rsp_a_q;
    assign bus.rsp_b     = rsp_b_q;

`ifdef EQ_ARB_STATS_EN
    logic [7:0] stat_cmps_q, stat_cmps_d;
    logic [7:0] stat_matches_q, stat_matches_d;

    // Saturating counters that move only on the response handshake.
    always_comb begin
        stat_cmps_d    = stat_cmps_q;
        stat_matches_d = stat_matches_q;
        if (state_q == RSP && bus.rsp_ready) begin
            if (stat_cmps_q != 8'hFF) begin
                stat_cmps_d = stat_cmps_q + 8'd1;
            end
            if (rsp_equal_q && stat_matches_q != 8'hFF) begin
                stat_matches_d = stat_matches_q + 8'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cmps_q    <= '0;
            stat_matches_q <= '0;
        end else begin
            stat_cmps_q    <= stat_cmps_d;
            stat_matches_q <= stat_matches_d;
        end
    end

    assign stat_cmps    = stat_cmps_q;
    assign stat_matches = stat_matches_q;
`endif

endmodule

// File: tb/tb_eq_share_arbiter.sv
// tb_eq_share_arbiter: directed bench for eq_share_arbiter with a
// transaction-level reference model checked on every cycle, plus literal
// expectations for reset, latency, fairness, backpressure, sweep and
// mid-operation reset. Works with or without EQ_ARB_STATS_EN.
module tb_eq_share_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eq_share_arbiter_if bus ();

    // The shared external comparator.
    assign bus.cmp_equal = (bus.cmp_a == bus.cmp_b);

`ifdef EQ_ARB_STATS_EN
    logic [7:0] stat_cmps;
    logic [7:0] stat_matches;
`endif

    eq_share_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef EQ_ARB_STATS_EN
        ,
        .stat_cmps    (stat_cmps),
        .stat_matches (stat_matches)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // busy: a compare has been accepted and its response not yet consumed.
    // age : cycles since acceptance (1 = comparing, 2 = response offered).
    int         m_rr = 0;
    bit         m_busy = 1'b0;
    int         m_age = 0;
    int         m_id = 0;
    logic [3:0] m_a = '0, m_b = '0;
    logic [3:0] m_cmp_a = '0, m_cmp_b = '0;
    int         m_cmps = 0, m_matches = 0;
    bit         armed = 1'b0;

    typedef struct {
        int         id;
        logic       eq;
        logic [3:0] a;
        logic [3:0] b;
        int         cyc;
    } rsp_t;
    rsp_t rsp_log[$];

    function automatic int pick(input logic [3:0] v, input int rr);
        for (int k = 0; k < 4; k++) begin
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    logic [3:0] exp_ready;
    logic       exp_valid;
    int         w;

    // Per-cycle compare at the falling edge, then advance the model across
    // the coming rising edge (inputs are stable from here to that edge).
    always @(negedge clk) begin
        cyc++;
        w = pick(bus.req_valid, m_rr);
        if (armed) begin
            exp_ready = '0;
            if (rst_n && !m_busy && w >= 0) exp_ready[w] = 1'b1;
            exp_valid = m_busy && (m_age == 2);
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
            chk("cmp_a", 32'(bus.cmp_a), 32'(m_cmp_a));
            chk("cmp_b", 32'(bus.cmp_b), 32'(m_cmp_b));
            if (exp_valid) begin
                chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
                chk("rsp_equal", 32'(bus.rsp_equal), 32'(m_a == m_b));
                chk("rsp_a", 32'(bus.rsp_a), 32'(m_a));
                chk("rsp_b", 32'(bus.rsp_b), 32'(m_b));
            end
`ifdef EQ_ARB_STATS_EN
            chk("stat_cmps", 32'(stat_cmps), 32'(m_cmps));
            chk("stat_matches", 32'(stat_matches), 32'(m_matches));
`endif
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                rsp_log.push_back('{int'(bus.rsp_id), bus.rsp_equal, bus.rsp_a, bus.rsp_b, cyc});
            end
        end

        if (!rst_n) begin
            armed     = 1'b1;
            m_rr      = 0;
            m_busy    = 1'b0;
            m_age     = 0;
            m_cmp_a   = '0;
            m_cmp_b   = '0;
            m_cmps    = 0;
            m_matches = 0;
        end else if (!m_busy) begin
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_id    = w;
                m_a     = bus.req_a[w*4 +: 4];
                m_b     = bus.req_b[w*4 +: 4];
                m_cmp_a = m_a;
                m_cmp_b = m_b;
                m_rr    = (w + 1) % 4;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (bus.rsp_ready) begin
            m_busy = 1'b0;
            if (m_cmps < 255) m_cmps++;
            if (m_a == m_b && m_matches < 255) m_matches++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b);
        bus.req_a[id*4 +: 4] = a;
        bus.req_b[id*4 +: 4] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int id);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) got = 1'b1;
            step();
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    // Returns the number of cycles from the grant to rsp_valid.
    task automatic wait_rsp(output int lat);
        bit got = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30 && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                lat = k;
            end
            step();
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int id, input logic [3:0] a, input logic [3:0] b, output int lat);
        set_op(id, a, b);
        bus.req_valid = 4'(1 << id);
        wait_grant(id);
        bus.req_valid = '0;
        wait_rsp(lat);
    endtask

    int lat;
    int eq_cnt;

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset with every requester asking.
        bus.req_valid = 4'hF;
        step();
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            chk("rst_cmp_a", 32'(bus.cmp_a), 32'h0);
            chk("rst_cmp_b", 32'(bus.cmp_b), 32'h0);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        wait_rsp(lat);
        chk("first_rsp_id", 32'(rsp_log.size() > 0 ? rsp_log[$].id : -1), 32'd0);

        // Single requester, equal and unequal operands.
        serve(2, 4'h9, 4'h9, lat);
        chk("single_lat", 32'(lat), 32'd2);
        chk("single_id", 32'(rsp_log[$].id), 32'd2);
        chk("single_eq", 32'(rsp_log[$].eq), 32'd1);
        chk("single_a", 32'(rsp_log[$].a), 32'h9);
        chk("single_b", 32'(rsp_log[$].b), 32'h9);
        serve(2, 4'h9, 4'h8, lat);
        chk("single_ne_lat", 32'(lat), 32'd2);
        chk("single_ne_eq", 32'(rsp_log[$].eq), 32'd0);
        chk("single_ne_b", 32'(rsp_log[$].b), 32'h8);

        // Fairness: all four valid continuously from rr = 0.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'(i));
        rsp_log.delete();
        bus.req_valid = 4'hF;
        repeat (19) step();
        bus.req_valid = '0;
        repeat (6) step();
        chk("fair_count", 32'(rsp_log.size() >= 6), 32'd1);
        if (rsp_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("fair_id%0d", i), 32'(rsp_log[i].id), 32'(i % 4));
                chk($sformatf("fair_eq%0d", i), 32'(rsp_log[i].eq), 32'd1);
                if (i > 0) chk($sformatf("fair_gap%0d", i), 32'(rsp_log[i].cyc - rsp_log[i-1].cyc), 32'd3);
            end
        end

        // Backpressure: response stalled 10 cycles while requester 0 waits.
        bus.rsp_ready = 1'b0;
        set_op(3, 4'h5, 4'h6);
        set_op(0, 4'hA, 4'hA);
        bus.req_valid = 4'b1000;
        wait_grant(3);
        bus.req_valid = 4'b0001;
        wait_rsp(lat);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_id", 32'(bus.rsp_id), 32'd3);
            chk("bp_eq", 32'(bus.rsp_equal), 32'd0);
            chk("bp_a", 32'(bus.rsp_a), 32'h5);
            chk("bp_b", 32'(bus.rsp_b), 32'h6);
            chk("bp_cmp_a", 32'(bus.cmp_a), 32'h5);
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("bp_next_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        wait_rsp(lat);
        chk("bp_after_id", 32'(rsp_log[$].id), 32'd0);
        chk("bp_after_eq", 32'(rsp_log[$].eq), 32'd1);

        // Exhaustive sweep on requester 1.
        do_reset();
        rsp_log.delete();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                serve(1, 4'(a), 4'(b), lat);
            end
        end
        eq_cnt = 0;
        foreach (rsp_log[i]) if (rsp_log[i].eq && rsp_log[i].id == 1 && rsp_log[i].a == rsp_log[i].b) eq_cnt++;
        chk("sweep_count", 32'(rsp_log.size()), 32'd256);
        chk("sweep_matches", 32'(eq_cnt), 32'd16);
`ifdef EQ_ARB_STATS_EN
        @(negedge clk);
        chk("sweep_stat_cmps", 32'(stat_cmps), 32'd255);
        chk("sweep_stat_matches", 32'(stat_matches), 32'd16);
        step();
`endif

        // Reset during CMP discards the compare; rr restarts at 0.
        set_op(2, 4'h7, 4'h7);
        bus.req_valid = 4'b0100;
        wait_grant(2);
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        rsp_log.delete();
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 3), 4'(i + 3));
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("mid_rst_grant", 32'(bus.req_ready), 32'h1);
        chk("mid_rst_cmp_a", 32'(bus.cmp_a), 32'h0);
`ifdef EQ_ARB_STATS_EN
        chk("mid_rst_stat_cmps", 32'(stat_cmps), 32'd0);
        chk("mid_rst_stat_matches", 32'(stat_matches), 32'd0);
`endif
        step();
        bus.req_valid = '0;
        wait_rsp(lat);
        chk("mid_rst_rsp_count", 32'(rsp_log.size()), 32'd1);
        chk("mid_rst_rsp_id", 32'(rsp_log.size() > 0 ? rsp_log[0].id : -1), 32'd0);
        chk("mid_rst_rsp_a", 32'(rsp_log.size() > 0 ? rsp_log[0].a : 4'hF), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
